flash_adc_scan: RTL and testbench

Parametrised, synthesizable back-end for a multi-channel bipolar flash ADC. It drives the analog channel mux and waits a programmable settling time. It then captures the comparator-bank thermometer code, optionally bubble-corrects it, and encodes it to a saturated two's-complement sample tagged with its channel number. It sits between the comparator bank/analog mux and the downstream sample consumer, and supports single-scan and continuous-scan modes.

---
 rtl/flash_adc_scan_if.sv | 40 ++++
 rtl/flash_adc_scan.sv | 178 +++++++++++++++++
 tb/tb_flash_adc_scan.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_adc_scan_if.sv
// ============================================================================
// Module      : flash_adc_scan_if
// Description : Scan-control and sample bus between the flash ADC back-end
//               and its controller/consumer. Master drives start/cont and the
//               comparator thermometer code; slave (the back-end) drives the
//               mux select, busy and the tagged sample outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface flash_adc_scan_if #(
   parameter int RES      = 8,
   parameter int CHANNELS = 4
);
   localparam int TW = (1 << RES) - 1;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic          start;
   logic          cont;
   logic [TW-1:0] therm_in;
   logic [CW-1:0] ch_sel;
   logic          busy;
   logic [RES-1:0] dout;
   logic [CW-1:0] dout_ch;
   logic          dout_valid;
   logic          ovr;
   logic          und;

   modport master (
      output start, cont, therm_in,
      input  ch_sel, busy, dout, dout_ch, dout_valid, ovr, und
   );

   modport slave (
      input  start, cont, therm_in,
      output ch_sel, busy, dout, dout_ch, dout_valid, ovr, und
   );
endinterface

`default_nettype wire

// File: rtl/flash_adc_scan.sv
// ============================================================================
// Module      : flash_adc_scan
// Description : Multi-channel bipolar flash ADC back-end. Steps the analog mux,
//               waits SETTLE cycles, captures the thermometer code, encodes it
//               to a saturated symmetric two's-complement sample tagged with
//               its channel. Single-scan and continuous-scan modes.
//               Optional macro FLASH_BUBBLE_CORR_EN enables 3-input majority
//               bubble correction of the captured code before counting.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_adc_scan #(
   parameter int RES      = 8,
   parameter int CHANNELS = 4,
   parameter int SETTLE   = 2
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   flash_adc_scan_if.slave  bus
);

   localparam int TW = (1 << RES) - 1;
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [7:0]     C_SETTLE_LOAD = 8'(SETTLE - 1);
   localparam logic [CW-1:0]  C_LAST_CH     = CW'(CHANNELS - 1);
   localparam logic [RES-1:0] C_HALF        = RES'(1 << (RES - 1));
   // Most negative legal code: -(2^(RES-1)-1), i.e. 2^(RES-1)+1 in RES bits.
   localparam logic [RES-1:0] C_MIN_CODE    = RES'((1 << (RES - 1)) + 1);
   localparam logic [RES-1:0] C_FULL        = RES'(TW);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2
   } state_t;

   state_t         r_state;
   logic [7:0]     r_cnt;
   logic [CW-1:0]  r_ch_sel;
   logic           r_busy;
   logic [TW-1:0]  r_t;
   logic           r_cap_valid;
   logic           r_cap_last;
   logic [CW-1:0]  r_cap_ch;

   logic [RES-1:0] r_dout;
   logic [CW-1:0]  r_dout_ch;
   logic           r_dout_valid;
   logic           r_dout_last;
   logic           r_ovr;
   logic           r_und;

   logic [TW-1:0]  w_t;
   logic [RES-1:0] w_n;
   logic [RES-1:0] w_code;
   logic           w_last;

   assign w_last = (r_ch_sel == C_LAST_CH);

`ifdef FLASH_BUBBLE_CORR_EN
   // Pad with t[-1]=1 below and t[TW]=0 above so the ends vote correctly.
   logic [TW+1:0] w_ext;
   assign w_ext = {1'b0, r_t, 1'b1};

   for (genvar i = 0; i < TW; i++) begin : g_bubble
      assign w_t[i] = (w_ext[i]   & w_ext[i+1]) |
                      (w_ext[i]   & w_ext[i+2]) |
                      (w_ext[i+1] & w_ext[i+2]);
   end
`else
   assign w_t = r_t;
`endif

   // Ones count of the (corrected) thermometer code, then offset and clamp.
   always_comb begin
      w_n = '0;
      for (int i = 0; i < TW; i++) begin
         w_n = w_n + RES'(w_t[i]);
      end
      if (w_n == '0) begin
         w_code = C_MIN_CODE;
      end else begin
         w_code = w_n - C_HALF;
      end
   end

   // Scan sequencer: mux stepping, settle timing, capture and busy tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_ch_sel    <= '0;
         r_busy      <= 1'b0;
         r_t         <= '0;
         r_cap_valid <= 1'b0;
         r_cap_last  <= 1'b0;
         r_cap_ch    <= '0;
      end else begin
         r_cap_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // busy still covers the trailing encode of the previous scan.
               if (bus.start && !r_busy) begin
                  r_state  <= S_SETTLE;
                  r_cnt    <= C_SETTLE_LOAD;
                  r_ch_sel <= '0;
                  r_busy   <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (r_cnt == '0) begin
                  r_state <= S_SAMPLE;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_SAMPLE: begin
               r_t         <= bus.therm_in;
               r_cap_valid <= 1'b1;
               r_cap_ch    <= r_ch_sel;
               r_cnt       <= C_SETTLE_LOAD;
               if (!w_last) begin
                  r_ch_sel   <= r_ch_sel + CW'(1);
                  r_state    <= S_SETTLE;
                  r_cap_last <= 1'b0;
               end else if (bus.cont) begin
                  r_ch_sel   <= '0;
                  r_state    <= S_SETTLE;
                  r_cap_last <= 1'b0;
               end else begin
                  r_state    <= S_IDLE;
                  r_cap_last <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
         if (r_dout_valid && r_dout_last) begin
            r_busy <= 1'b0;
         end
      end
   end

   // Encode stage: register the sample one cycle after capture, hold between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout       <= '0;
         r_dout_ch    <= '0;
         r_dout_valid <= 1'b0;
         r_dout_last  <= 1'b0;
         r_ovr        <= 1'b0;
         r_und        <= 1'b0;
      end else begin
         r_dout_valid <= r_cap_valid;
         r_dout_last  <= r_cap_valid & r_cap_last;
         if (r_cap_valid) begin
            r_dout    <= w_code;
            r_dout_ch <= r_cap_ch;
            r_ovr     <= (w_n == C_FULL);
            r_und     <= (w_n <= RES'(1));
         end
      end
   end

   assign bus.ch_sel     = r_ch_sel;
   assign bus.busy       = r_busy;
   assign bus.dout       = r_dout;
   assign bus.dout_ch    = r_dout_ch;
   assign bus.dout_valid = r_dout_valid;
   assign bus.ovr        = r_ovr;
   assign bus.und        = r_und;

endmodule

`default_nettype wire

// File: tb/tb_flash_adc_scan.sv
// ============================================================================
// Module      : tb_flash_adc_scan
// Description : Self-checking bench for flash_adc_scan. Main instance uses
//               RES=8/CHANNELS=4/SETTLE=2; a second RES=4/CHANNELS=1/SETTLE=1
//               instance covers the small-parameter corner. Honours the
//               FLASH_BUBBLE_CORR_EN macro in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flash_adc_scan;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   flash_adc_scan_if #(.RES(8), .CHANNELS(4)) b8 ();
   flash_adc_scan_if #(.RES(4), .CHANNELS(1)) b4 ();

   flash_adc_scan #(.RES(8), .CHANNELS(4), .SETTLE(2)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b8)
   );

   flash_adc_scan #(.RES(4), .CHANNELS(1), .SETTLE(1)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b4)
   );

   typedef struct {
      int         cyc;
      logic [7:0] d;
      logic [1:0] ch;
      logic       ovr;
      logic       und;
   } strobe_t;

   typedef struct {
      int         cyc;
      logic [3:0] d;
      logic       ovr;
      logic       und;
   } strobe4_t;

   strobe_t      sq[$];
   strobe4_t     sq4[$];
   logic [254:0] pats[4];
   logic [14:0]  p4;
   int           cyc = 0;
   int           e0 = 0;
   int           fall_cyc = -1;
   int           errors = 0;
   int           checks = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Thermometer code with the n lowest comparators set.
   function automatic logic [254:0] therm_of(input int n);
      logic [254:0] t = '0;
      for (int i = 0; i < n; i++) t[i] = 1'b1;
      return t;
   endfunction

   // Effective ones count the converter should see for a raw comparator word.
   function automatic int ones_model(input logic [254:0] t);
      int n = 0;
      int lo, mid, hi;
      for (int i = 0; i < 255; i++) begin
         mid = int'(t[i]);
`ifdef FLASH_BUBBLE_CORR_EN
         lo = 1;
         hi = 0;
         if (i > 0)   lo = int'(t[i-1]);
         if (i < 254) hi = int'(t[i+1]);
         if (lo + mid + hi >= 2) n++;
`else
         lo = 0;
         hi = 0;
         n = n + mid + lo + hi;
`endif
      end
      return n;
   endfunction

   // Symmetric saturated two's-complement code for ones count n at RES=8.
   function automatic logic [7:0] exp8(input int n);
      int c;
      c = n - 128;
      if (c < -127) c = -127;
      return c[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      if (b8.dout_valid) sq.push_back(strobe_t'{cyc, b8.dout, b8.dout_ch, b8.ovr, b8.und});
      if (b4.dout_valid) sq4.push_back(strobe4_t'{cyc, b4.dout, b4.ovr, b4.und});
      if (!b8.busy && fall_cyc < 0) fall_cyc = cyc;
      b8.therm_in = pats[b8.ch_sel];
      b4.therm_in = p4;
   endtask

   task automatic start8(input string tag);
      sq.delete();
      b8.start = 1'b1;
      tick();
      b8.start = 1'b0;
      e0 = cyc;
      fall_cyc = -1;
      check({tag, "_busy_after_start"}, 64'(b8.busy), 64'd1);
      check({tag, "_ch_after_start"}, 64'(b8.ch_sel), 64'd0);
   endtask

   task automatic wait_idle8(input string tag, input int budget);
      int k = 0;
      while (fall_cyc < 0 && k < budget) begin
         tick();
         k++;
      end
      check({tag, "_idle_timeout"}, 64'(fall_cyc >= 0), 64'd1);
   endtask

   // Compare captured strobes against the model for nscans full scans.
   task automatic verify8(input string tag, input int nscans);
      int n;
      check({tag, "_count"}, 64'(sq.size()), 64'(4 * nscans));
      for (int k = 0; k < sq.size() && k < 4 * nscans; k++) begin
         n = ones_model(pats[k % 4]);
         check($sformatf("%s_cyc%0d", tag, k), 64'(sq[k].cyc), 64'(e0 + 4 + 3 * k));
         check($sformatf("%s_ch%0d", tag, k), 64'(sq[k].ch), 64'(k % 4));
         check($sformatf("%s_dout%0d", tag, k), 64'(sq[k].d), 64'(exp8(n)));
         check($sformatf("%s_ovr%0d", tag, k), 64'(sq[k].ovr), 64'(n == 255));
         check($sformatf("%s_und%0d", tag, k), 64'(sq[k].und), 64'(n <= 1));
      end
      if (sq.size() > 0)
         check({tag, "_busy_fall"}, 64'(fall_cyc), 64'(sq[sq.size()-1].cyc + 1));
   endtask

   initial begin
      logic [254:0] bub;
      int           e4;

      b8.start = 1'b0;
      b8.cont = 1'b0;
      b8.therm_in = '0;
      b4.start = 1'b0;
      b4.cont = 1'b0;
      b4.therm_in = '0;
      p4 = '0;
      for (int c = 0; c < 4; c++) pats[c] = '0;

      // Reset state.
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_ch_sel", 64'(b8.ch_sel), 64'd0);
      check("rst_busy", 64'(b8.busy), 64'd0);
      check("rst_dout", 64'(b8.dout), 64'd0);
      check("rst_dout_ch", 64'(b8.dout_ch), 64'd0);
      check("rst_valid", 64'(b8.dout_valid), 64'd0);
      check("rst_ovr_und", 64'({b8.ovr, b8.und}), 64'd0);
      check("rst4_outs", 64'({b4.busy, b4.dout, b4.dout_valid, b4.ovr, b4.und}), 64'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Directed single scan: 128, 255, 0, 200 ones.
      pats[0] = therm_of(128);
      pats[1] = therm_of(255);
      pats[2] = therm_of(0);
      pats[3] = therm_of(200);
      start8("single");
      wait_idle8("single", 40);
      verify8("single", 1);
      if (sq.size() == 4) begin
         check("single_const0", 64'(sq[0].d), 64'h00);
         check("single_const1", 64'({sq[1].d, sq[1].ovr}), 64'({8'h7F, 1'b1}));
         check("single_const2", 64'({sq[2].d, sq[2].und}), 64'({8'h81, 1'b1}));
         check("single_const3", 64'(sq[3].d), 64'h48);
      end
      // Outputs hold between strobes.
      repeat (3) tick();
      check("hold_dout", 64'(b8.dout), 64'h48);
      check("hold_dout_ch", 64'(b8.dout_ch), 64'd3);

      // Randomized single scans with clean thermometer codes.
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) pats[c] = therm_of(int'($urandom_range(0, 255)));
         start8($sformatf("rand%0d", r));
         wait_idle8($sformatf("rand%0d", r), 40);
         verify8($sformatf("rand%0d", r), 1);
         repeat (int'($urandom_range(0, 3))) tick();
      end

      // Bubbles and sparkles.
      bub = therm_of(100);
      bub[50] = 1'b0;
      bub[110] = 1'b1;
      pats[0] = bub;
      bub = therm_of(100);
      bub[110] = 1'b1;
      pats[1] = bub;
      pats[2] = therm_of(100);
      pats[3] = therm_of(101);
      start8("bubble");
      wait_idle8("bubble", 40);
      verify8("bubble", 1);
      if (sq.size() == 4) begin
         check("bubble_const0", 64'(sq[0].d), 64'hE4);
`ifdef FLASH_BUBBLE_CORR_EN
         check("bubble_const1", 64'(sq[1].d), 64'hE4);
`else
         check("bubble_const1", 64'(sq[1].d), 64'hE5);
`endif
      end

      // Continuous mode for two scans with an ignored mid-scan start.
      for (int c = 0; c < 4; c++) pats[c] = therm_of(int'($urandom_range(0, 255)));
      b8.cont = 1'b1;
      start8("cont");
      while (cyc < e0 + 7) tick();
      b8.start = 1'b1;
      tick();
      b8.start = 1'b0;
      while (cyc < e0 + 15) tick();
      b8.cont = 1'b0;
      wait_idle8("cont", 60);
      verify8("cont", 2);

      // Reset during channel 2 settle.
      for (int c = 0; c < 4; c++) pats[c] = therm_of(200);
      start8("rstmid");
      while (cyc < e0 + 7) tick();
      check("rstmid_pre_ch", 64'(b8.ch_sel), 64'd2);
      rst_n = 1'b0;
      #1;
      check("rstmid_outs", 64'({b8.ch_sel, b8.busy, b8.dout, b8.dout_ch, b8.dout_valid, b8.ovr, b8.und}), 64'd0);
      sq.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (12) tick();
      check("rstmid_no_strobe", 64'(sq.size()), 64'd0);
      check("rstmid_idle", 64'({b8.busy, b8.ch_sel}), 64'd0);

      // Small-parameter instance: RES=4, CHANNELS=1, SETTLE=1, continuous.
      p4 = 15'h7FFF;
      b4.cont = 1'b1;
      sq4.delete();
      b4.start = 1'b1;
      tick();
      b4.start = 1'b0;
      e4 = cyc;
      repeat (10) tick();
      check("r4_full_count", 64'(sq4.size()), 64'd4);
      for (int k = 0; k < sq4.size(); k++) begin
         check($sformatf("r4_full_cyc%0d", k), 64'(sq4[k].cyc), 64'(e4 + 3 + 2 * k));
         check($sformatf("r4_full_val%0d", k), 64'({sq4[k].d, sq4[k].ovr, sq4[k].und}), 64'({4'h7, 1'b1, 1'b0}));
      end
      p4 = 15'h00FF;
      repeat (3) tick();
      sq4.delete();
      repeat (8) tick();
      check("r4_mid_count", 64'(sq4.size()), 64'd4);
      for (int k = 0; k < sq4.size(); k++) begin
         check($sformatf("r4_mid_val%0d", k), 64'({sq4[k].d, sq4[k].ovr, sq4[k].und}), 64'({4'h0, 1'b0, 1'b0}));
         if (k > 0)
            check($sformatf("r4_mid_gap%0d", k), 64'(sq4[k].cyc - sq4[k-1].cyc), 64'd2);
      end
      b4.cont = 1'b0;
      repeat (6) tick();
      check("r4_idle", 64'(b4.busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
